// File: rtl/spi_controller.sv
// SPI master (mode 0) with a small register interface and byte FIFOs.
// Bus side: DATA/STAT/CTRL registers, single-cycle req, resp one cycle later.
// Engine side: IDLE/LOAD/LOW/HIGH state machine shifting MSB first.
module spi_controller #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] addr,
   input  logic        w_rb,
   input  logic [1:0]  acc,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        req,
   output logic        resp,
   output logic        fault,
   output logic        sck,
   output logic        mosi,
   input  logic        miso,
   output logic        csn
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_LOW  = 2'd2,
      S_HIGH = 2'd3
   } state_t;

   // Control register
   logic [7:0]    r_div;
   logic          r_cs;

   // FIFO storage and bookkeeping
   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp;
   logic [AW:0]   r_tx_cnt;
   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_wp, r_rx_rp;
   logic [AW:0]   r_rx_cnt;

   // Engine registers and their next values
   state_t        r_state, w_state_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [7:0]    r_cnt, w_cnt_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   logic [7:0]    r_div_lat, w_div_nxt;
   logic          r_sck, w_sck_nxt;
   logic          r_mosi, w_mosi_nxt;

   // Bus response registers
   logic          r_resp;
   logic [31:0]   r_rdata;

   // Decode and status wires
   logic          w_off_data, w_off_stat, w_off_ctrl;
   logic          w_misalign, w_illegal, w_ok;
   logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_ctrl_wr;
   logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_busy;
   logic [7:0]    w_tx_head, w_rx_head;
   logic [31:0]   w_stat, w_rd_val;
   logic          w_unused;

   assign w_unused   = &{1'b0, addr[31:4], wdata[31:9]};

   assign w_tx_full  = (r_tx_cnt == C_FULL);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == C_FULL);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_busy     = (r_state != S_IDLE) | ~w_tx_empty;
   assign w_tx_head  = r_tx_mem[r_tx_rp];
   assign w_rx_head  = r_rx_mem[r_rx_rp];
   assign w_stat     = {27'h0, w_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

   // Address/size decode; every illegal combination is folded into one flag
   // so a faulting access can be suppressed everywhere with a single term.
   assign w_off_data = (addr[3:0] == 4'h0);
   assign w_off_stat = (addr[3:0] == 4'h4);
   assign w_off_ctrl = (addr[3:0] == 4'h8);
   assign w_misalign = ((acc == 2'd1) & addr[0]) | ((acc == 2'd2) & (addr[1:0] != 2'b00));
   assign w_illegal  = ~(w_off_data | w_off_stat | w_off_ctrl)
                     | (w_off_data & (acc != 2'd0))
                     | ((w_off_stat | w_off_ctrl) & (acc != 2'd2))
                     | (w_off_stat & w_rb)
                     | (w_off_data & w_rb & w_tx_full)
                     | w_misalign;
   assign fault      = req & w_illegal;
   assign w_ok       = req & ~w_illegal;
   assign w_tx_push  = w_ok & w_off_data & w_rb;
   assign w_rx_pop   = w_ok & w_off_data & ~w_rb & ~w_rx_empty;
   assign w_ctrl_wr  = w_ok & w_off_ctrl & w_rb;

   assign rdata = r_rdata;
   assign resp  = r_resp;
   assign sck   = r_sck;
   assign mosi  = r_mosi;
   assign csn   = ~r_cs;

   // Read-data mux for legal reads; an empty RX reads as zero without popping
   always_comb begin
      w_rd_val = 32'h0;
      if (w_off_data)      w_rd_val = {24'h0, (w_rx_empty ? 8'h00 : w_rx_head)};
      else if (w_off_stat) w_rd_val = w_stat;
      else if (w_off_ctrl) w_rd_val = {23'h0, r_cs, r_div};
   end

   // Response strobe and registered read data
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_resp  <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         r_resp  <= req;
         r_rdata <= (w_ok & ~w_rb) ? w_rd_val : 32'h0;
      end
   end

   // CTRL register; CS is writable at any time, DIV is sampled by the engine at LOAD
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_div <= 8'h0;
         r_cs  <= 1'b0;
      end else if (w_ctrl_wr) begin
         r_div <= wdata[7:0];
         r_cs  <= wdata[8];
      end
   end

   // TX FIFO storage
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
   end

   // TX FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         if (w_tx_push & ~w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
         else if (~w_tx_push & w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
      end
   end

   // RX FIFO storage
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_shift;
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         if (w_rx_push & ~w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
         else if (~w_rx_push & w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
      end
   end

   // Engine state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Engine next-state and datapath. The byte is popped on the edge entering
   // LOAD so the shift register and mosi already hold it during LOAD. The
   // shift happens on the rising sck edge together with the miso capture;
   // the falling edge then just presents the new MSB on mosi.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_div_nxt   = r_div_lat;
      w_sck_nxt   = r_sck;
      w_mosi_nxt  = r_mosi;
      w_tx_pop    = 1'b0;
      w_rx_push   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (~w_tx_empty & ~w_rx_full) begin
               w_state_nxt = S_LOAD;
               w_tx_pop    = 1'b1;
               w_shift_nxt = w_tx_head;
               w_div_nxt   = r_div;
               w_mosi_nxt  = w_tx_head[7];
               w_sck_nxt   = 1'b0;
               w_cnt_nxt   = 8'h0;
               w_bit_nxt   = 3'd0;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = 8'h0;
         end
         S_LOW: begin
            if (r_cnt == r_div_lat) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = 8'h0;
               w_sck_nxt   = 1'b1;
               w_shift_nxt = {r_shift[6:0], miso};
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_HIGH: begin
            if (r_cnt == r_div_lat) begin
               w_cnt_nxt = 8'h0;
               w_sck_nxt = 1'b0;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_IDLE;
                  w_rx_push   = 1'b1;
                  w_mosi_nxt  = 1'b0;
               end else begin
                  w_state_nxt = S_LOW;
                  w_bit_nxt   = r_bit + 3'd1;
                  w_mosi_nxt  = r_shift[7];
               end
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Engine datapath registers; reset drops any partial byte
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shift   <= 8'h0;
         r_cnt     <= 8'h0;
         r_bit     <= 3'd0;
         r_div_lat <= 8'h0;
         r_sck     <= 1'b0;
         r_mosi    <= 1'b0;
      end else begin
         r_shift   <= w_shift_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit     <= w_bit_nxt;
         r_div_lat <= w_div_nxt;
         r_sck     <= w_sck_nxt;
         r_mosi    <= w_mosi_nxt;
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: register access, loopback transfers,
// FIFO full behaviour, DIV change mid-byte and reset mid-byte.
module tb_spi_controller;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] addr;
   logic        w_rb;
   logic [1:0]  acc;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        req;
   logic        resp;
   logic        fault;
   logic        sck;
   logic        mosi;
   logic        miso;
   logic        csn;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   int          hi_len_q[$];
   int          hi_run = 0;

   spi_controller #(.FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .addr  (addr),
      .w_rb  (w_rb),
      .acc   (acc),
      .wdata (wdata),
      .rdata (rdata),
      .req   (req),
      .resp  (resp),
      .fault (fault),
      .sck   (sck),
      .mosi  (mosi),
      .miso  (miso),
      .csn   (csn)
   );

   // Loopback: slave returns what the master sends
   assign miso = mosi;

   // Clock
   always #5 clk = ~clk;

   // Record the length in clk cycles of every completed sck high pulse
   always @(posedge clk) begin
      #1;
      if (sck) hi_run = hi_run + 1;
      else if (hi_run != 0) begin
         hi_len_q.push_back(hi_run);
         hi_run = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus access: req for one cycle, fault sampled on the req cycle,
   // resp/rdata sampled one cycle later.
   task automatic bus_acc(input logic [3:0] a, input logic wr, input logic [1:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic flt, output logic rsp);
      @(posedge clk); #1;
      addr  = {28'h0, a};
      w_rb  = wr;
      acc   = sz;
      wdata = wd;
      req   = 1'b1;
      #1 flt = fault;
      @(posedge clk); #1;
      req   = 1'b0;
      w_rb  = 1'b0;
      wdata = 32'h0;
      rsp   = resp;
      rd    = rdata;
   endtask

   task automatic reg_rd(input logic [3:0] a, input logic [1:0] sz, input logic [31:0] exp_d,
                         input logic exp_f, input string tag);
      logic [31:0] d;
      logic        f, r;
      bus_acc(a, 1'b0, sz, 32'h0, d, f, r);
      check({tag, "_fault"}, f, exp_f);
      check({tag, "_resp"}, r, 1'b1);
      if (!exp_f) check({tag, "_rdata"}, d, exp_d);
   endtask

   task automatic reg_wr(input logic [3:0] a, input logic [1:0] sz, input logic [31:0] wd,
                         input logic exp_f, input string tag);
      logic [31:0] d;
      logic        f, r;
      bus_acc(a, 1'b1, sz, wd, d, f, r);
      check({tag, "_fault"}, f, exp_f);
      check({tag, "_resp"}, r, 1'b1);
   endtask

   task automatic data_wr(input logic [7:0] b, input string tag);
      reg_wr(4'h0, 2'd0, {24'h0, b}, 1'b0, tag);
      exp_q.push_back(b);
   endtask

   task automatic data_rd(input string tag);
      logic [7:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      reg_rd(4'h0, 2'd0, {24'h0, e}, 1'b0, tag);
   endtask

   // Trace one byte at DIV=1 starting right after the DATA write returns.
   // Sample 1 is LOAD (mosi=bit7), bit i occupies samples 2+4i..5+4i with
   // sck high in the last two, sample 34 onward is idle.
   task automatic trace_byte_div1(input logic [7:0] b, input string tag);
      logic [35:0] sck_tr, mosi_tr, csn_tr, sck_ex, mosi_ex;
      for (int k = 0; k < 36; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         sck_tr[k]  = sck;
         mosi_tr[k] = mosi;
         csn_tr[k]  = csn;
         sck_ex[k]  = (k >= 2) && (k <= 33) && (((k - 2) % 4) >= 2);
         if (k == 1)                  mosi_ex[k] = b[7];
         else if (k >= 2 && k <= 33)  mosi_ex[k] = b[7 - ((k - 2) / 4)];
         else                         mosi_ex[k] = 1'b0;
      end
      check({tag, "_sck_trace"}, sck_tr, sck_ex);
      check({tag, "_mosi_trace"}, mosi_tr, mosi_ex);
      check({tag, "_csn_trace"}, csn_tr, 36'h0);
   endtask

   // Bound on total run time
   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      rstn  = 1'b0;
      req   = 1'b0;
      w_rb  = 1'b0;
      acc   = 2'd0;
      addr  = 32'h0;
      wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_resp", resp, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_csn", csn, 1'b1);
      rstn = 1'b1;

      // Status after reset, resp is a single-cycle strobe
      reg_rd(4'h4, 2'd2, 32'h0000_000A, 1'b0, "stat_after_rst");
      @(posedge clk); #1;
      check("resp_one_shot", resp, 1'b0);

      // Illegal accesses leave everything untouched
      reg_rd(4'h0, 2'd2, 32'h0, 1'b1, "data_word_rd");
      reg_wr(4'h8, 2'd0, 32'h0000_01FF, 1'b1, "ctrl_byte_wr");
      reg_rd(4'hC, 2'd2, 32'h0, 1'b1, "rd_0xc");
      reg_wr(4'h4, 2'd2, 32'hFFFF_FFFF, 1'b1, "stat_wr");
      reg_rd(4'h8, 2'd3, 32'h0, 1'b1, "ctrl_acc3");
      reg_rd(4'h2, 2'd1, 32'h0, 1'b1, "half_rd_0x2");
      reg_rd(4'h8, 2'd2, 32'h0, 1'b0, "ctrl_unchanged");
      reg_rd(4'h4, 2'd2, 32'h0000_000A, 1'b0, "stat_unchanged");
      check("csn_unchanged", csn, 1'b1);

      // Loopback byte at DIV=1 with CS asserted
      reg_wr(4'h8, 2'd2, 32'h0000_0101, 1'b0, "ctrl_wr_101");
      check("csn_after_ctrl", csn, 1'b0);
      reg_rd(4'h8, 2'd2, 32'h0000_0101, 1'b0, "ctrl_rd_101");
      data_wr(8'hA5, "data_wr_a5");
      trace_byte_div1(8'hA5, "byte_a5");
      reg_rd(4'h4, 2'd2, 32'h0000_0002, 1'b0, "stat_rx_one");
      data_rd("data_rd_a5");
      reg_rd(4'h4, 2'd2, 32'h0000_000A, 1'b0, "stat_drained");
      reg_rd(4'h0, 2'd0, 32'h0, 1'b0, "data_rd_empty");

      // DIV 0 -> 3 during the first byte: only the second byte slows down
      reg_wr(4'h8, 2'd2, 32'h0000_0100, 1'b0, "ctrl_wr_div0");
      hi_len_q.delete();
      data_wr(8'h3C, "data_wr_3c");
      data_wr(8'hC3, "data_wr_c3");
      reg_wr(4'h8, 2'd2, 32'h0000_0103, 1'b0, "ctrl_wr_div3");
      repeat (100) @(posedge clk);
      #1;
      check("div_pulse_count", hi_len_q.size(), 16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("div_pulse_%0d", i),
               (i < hi_len_q.size()) ? hi_len_q[i] : -1,
               (i < 8) ? 1 : 4);
      end
      data_rd("data_rd_3c");
      data_rd("data_rd_c3");

      // Fill RX, then TX: engine must hold and the fifth write must fault
      reg_wr(4'h8, 2'd2, 32'h0000_0100, 1'b0, "ctrl_wr_div0b");
      data_wr(8'h11, "fill_rx_11");
      data_wr(8'h22, "fill_rx_22");
      data_wr(8'h33, "fill_rx_33");
      data_wr(8'h44, "fill_rx_44");
      repeat (100) @(posedge clk);
      reg_rd(4'h4, 2'd2, 32'h0000_0006, 1'b0, "stat_rx_full");
      hi_len_q.delete();
      data_wr(8'h55, "fill_tx_55");
      data_wr(8'h66, "fill_tx_66");
      data_wr(8'h77, "fill_tx_77");
      data_wr(8'h88, "fill_tx_88");
      reg_wr(4'h0, 2'd0, 32'h0000_0099, 1'b1, "tx_full_wr");
      reg_rd(4'h4, 2'd2, 32'h0000_0015, 1'b0, "stat_both_full");
      repeat (10) @(posedge clk);
      #1;
      check("engine_held_pulses", hi_len_q.size(), 0);
      check("engine_held_sck", sck, 1'b0);
      for (int i = 0; i < 4; i++) data_rd($sformatf("drain_rx_%0d", i));
      repeat (100) @(posedge clk);
      for (int i = 0; i < 4; i++) data_rd($sformatf("drain_tx_%0d", i));
      reg_rd(4'h4, 2'd2, 32'h0000_000A, 1'b0, "stat_all_empty");

      // Reset during bit 4 aborts the byte
      reg_wr(4'h8, 2'd2, 32'h0000_0101, 1'b0, "ctrl_wr_rst");
      hi_len_q.delete();
      reg_wr(4'h0, 2'd0, 32'h0000_00F0, 1'b0, "data_wr_f0");
      repeat (20) @(posedge clk);
      #2;
      check("mid_byte_sck", sck, 1'b1);
      check("mid_byte_pulses", hi_len_q.size(), 4);
      rstn = 1'b0;
      #1;
      check("rst_mid_csn", csn, 1'b1);
      check("rst_mid_sck", sck, 1'b0);
      check("rst_mid_mosi", mosi, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid_resp", resp, 1'b0);
      rstn = 1'b1;
      hi_len_q.delete();
      reg_rd(4'h4, 2'd2, 32'h0000_000A, 1'b0, "stat_after_rst_mid");
      reg_rd(4'h8, 2'd2, 32'h0, 1'b0, "ctrl_after_rst_mid");
      reg_rd(4'h0, 2'd0, 32'h0, 1'b0, "rx_empty_after_rst_mid");
      repeat (40) @(posedge clk);
      #1;
      check("no_pulses_after_rst", hi_len_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
